// File: rtl/romulus_pkg.sv
// Shared types and constants for the pdi padding front end: FSM states,
// block geometry and the leading-byte lane mask table.
package romulus_pkg;

  typedef enum logic {
    DATA = 1'b0,
    PAD  = 1'b1
  } state_t;

  localparam int BLK_WORDS = 4;
  localparam int BLK_BYTES = 16;

  // Entry n keeps the first n stream bytes; bit 3 is lane [31:24].
  localparam logic [4:0][3:0] LANE_MASK_TBL = {4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

  function automatic logic [3:0] lane_mask(input logic [2:0] bytes);
    logic [3:0] r_sel;
    if (bytes > 3'd4) r_sel = LANE_MASK_TBL[3'd4];
    else              r_sel = LANE_MASK_TBL[bytes];
    return r_sel;
  endfunction

endpackage

// File: rtl/pdi_lane_mask.sv
// Combinational shaping of one data word: zero the lanes past the valid
// bytes, optionally place the block length in the low byte, form decrypt lanes.
module pdi_lane_mask
  import romulus_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_bytes,
  input  logic        i_dec,
  input  logic        i_len_en,
  input  logic [7:0]  i_len,
  output logic [31:0] o_word,
  output logic [3:0]  o_dec
);

  logic [3:0]  w_mask;
  logic [31:0] w_masked;

  assign w_mask = lane_mask(i_bytes);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign w_masked[8*g +: 8] = w_mask[g] ? i_word[8*g +: 8] : 8'h00;
  end

  // The length byte never counts as ciphertext, so its decrypt lane is forced off.
  assign o_word = i_len_en ? {w_masked[31:8], i_len} : w_masked;
  assign o_dec  = i_dec ? (w_mask & {3'b111, ~i_len_en}) : 4'b0000;

endmodule

// File: rtl/pdi_pad_32b.sv
// PDI feeder: masks input lanes, pads each segment to a whole 4-word block
// and tags partial blocks with their byte count. Option: PDI_BYTE_SWAP_EN.
module pdi_pad_32b #(
  parameter int FFTYPE    = 1,
  parameter int BLK_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pdi,
  input  logic        pdi_valid,
  input  logic [2:0]  pdi_bytes,
  input  logic        pdi_last,
  input  logic        dec_mode,
  output logic        pdi_ready,
  output logic [31:0] pdi_o,
  output logic [3:0]  decrypt_o,
  output logic [1:0]  word_idx,
  output logic        blk_last,
  output logic        blk_partial,
  output logic        o_valid,
  input  logic        o_ready
);
  import romulus_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(BLK_WORDS - 1);
  localparam int         LEN_W    = $clog2(BLK_BYTES + 1);

  state_t             r_state;
  logic [1:0]         r_wc;
  logic [LEN_W-1:0]   r_len;
  logic [31:0]        r_pdi_o;
  logic [3:0]         r_dec_o;
  logic [1:0]         r_word_idx;
  logic               r_blk_last;
  logic               r_blk_partial;
  logic               r_o_valid;

  logic               w_out_free;
  logic [31:0]        w_pdi_in;
  logic [LEN_W-1:0]   w_blk_len;
  logic               w_len_en;
  logic [31:0]        w_lane_word;
  logic [3:0]         w_lane_dec;

`ifdef PDI_BYTE_SWAP_EN
  assign w_pdi_in = {pdi[7:0], pdi[15:8], pdi[23:16], pdi[31:24]};
`else
  assign w_pdi_in = pdi;
`endif

  assign w_out_free = ~r_o_valid | o_ready;
  assign pdi_ready  = (r_state == DATA) & w_out_free;
  assign w_blk_len  = LEN_W'({r_wc, 2'b00}) + LEN_W'(pdi_bytes);
  assign w_len_en   = pdi_last & (r_wc == LAST_IDX) & (pdi_bytes < 3'd4);

  pdi_lane_mask u_lane_mask (
    .i_word   (w_pdi_in),
    .i_bytes  (pdi_bytes),
    .i_dec    (dec_mode),
    .i_len_en (w_len_en),
    .i_len    (8'(w_blk_len)),
    .o_word   (w_lane_word),
    .o_dec    (w_lane_dec)
  );

  if (FFTYPE == 1) begin : g_std_ff
    // The output register only reloads when its current word is consumed or empty.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state       <= DATA;
        r_wc          <= 2'd0;
        r_len         <= '0;
        r_pdi_o       <= 32'h0;
        r_dec_o       <= 4'h0;
        r_word_idx    <= 2'd0;
        r_blk_last    <= 1'b0;
        r_blk_partial <= 1'b0;
        r_o_valid     <= 1'b0;
      end else if (w_out_free) begin
        unique case (r_state)
          DATA: begin
            if (pdi_valid) begin
              r_o_valid  <= 1'b1;
              r_pdi_o    <= w_lane_word;
              r_dec_o    <= w_lane_dec;
              r_word_idx <= r_wc;
              if (pdi_last && r_wc == LAST_IDX) begin
                r_blk_last    <= 1'b1;
                r_blk_partial <= (pdi_bytes < 3'd4);
                r_wc          <= 2'd0;
              end else if (pdi_last) begin
                r_blk_last    <= 1'b0;
                r_blk_partial <= 1'b0;
                r_len         <= w_blk_len;
                r_wc          <= r_wc + 2'd1;
                r_state       <= PAD;
              end else begin
                r_blk_last    <= 1'b0;
                r_blk_partial <= 1'b0;
                r_wc          <= r_wc + 2'd1;
              end
            end else begin
              r_o_valid <= 1'b0;
            end
          end
          PAD: begin
            r_o_valid     <= 1'b1;
            r_dec_o       <= 4'h0;
            r_word_idx    <= r_wc;
            r_pdi_o       <= (r_wc == LAST_IDX) ? {24'h0, 8'(r_len)} : 32'h0;
            r_blk_last    <= (r_wc == LAST_IDX);
            r_blk_partial <= (r_wc == LAST_IDX);
            if (r_wc == LAST_IDX) begin
              r_wc    <= 2'd0;
              r_state <= DATA;
            end else begin
              r_wc <= r_wc + 2'd1;
            end
          end
          default: r_state <= DATA;
        endcase
      end
    end
  end

  assign pdi_o       = r_pdi_o;
  assign decrypt_o   = r_dec_o;
  assign word_idx    = r_word_idx;
  assign blk_last    = r_blk_last;
  assign blk_partial = r_blk_partial;
  assign o_valid     = r_o_valid;

endmodule

// File: tb/tb_pdi_pad_32b.sv
// Self-checking bench for pdi_pad_32b: a segment-level model predicts every
// output word, a monitor compares on each handshake, literals pin key words.
module tb_pdi_pad_32b;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pdi;
  logic        pdi_valid;
  logic [2:0]  pdi_bytes;
  logic        pdi_last;
  logic        dec_mode;
  logic        pdi_ready;
  logic [31:0] pdi_o;
  logic [3:0]  decrypt_o;
  logic [1:0]  word_idx;
  logic        blk_last;
  logic        blk_partial;
  logic        o_valid;
  logic        o_ready;

  int errCount   = 0;
  int checkCount = 0;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  dec;
    logic [1:0]  idx;
    logic        bl;
    logic        bp;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monExp;
  logic [31:0] obsWord[$];
  logic [3:0]  obsDec[$];
  logic [1:0]  obsIdx[$];
  logic        obsBl[$];
  logic        obsBp[$];

  logic [31:0] segData[16];
  int          segBytes[16];
  logic        segDec[16];

  pdi_pad_32b dut (
    .clk         (clk),
    .rst         (rst),
    .pdi         (pdi),
    .pdi_valid   (pdi_valid),
    .pdi_bytes   (pdi_bytes),
    .pdi_last    (pdi_last),
    .dec_mode    (dec_mode),
    .pdi_ready   (pdi_ready),
    .pdi_o       (pdi_o),
    .decrypt_o   (decrypt_o),
    .word_idx    (word_idx),
    .blk_last    (blk_last),
    .blk_partial (blk_partial),
    .o_valid     (o_valid),
    .o_ready     (o_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expand a whole segment into the block words it must produce.
  task automatic modelSegment(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t        e;
      exp_t        z;
      logic [31:0] w;
      int          k;
      int          b;
      int          len;
      w = segData[i];
`ifdef PDI_BYTE_SWAP_EN
      w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
      k   = i % 4;
      b   = segBytes[i];
      len = 4 * k + b;
      e.word = 32'h0;
      e.dec  = 4'h0;
      for (int j = 0; j < 4; j++) begin
        if (j < b) begin
          e.word[31-8*j -: 8] = w[31-8*j -: 8];
          e.dec[3-j]          = segDec[i];
        end
      end
      e.idx = 2'(k);
      e.bl  = 1'b0;
      e.bp  = 1'b0;
      if (i == n - 1 && k == 3) begin
        e.bl = 1'b1;
        if (b < 4) begin
          e.word[7:0] = 8'(len);
          e.dec[0]    = 1'b0;
          e.bp        = 1'b1;
        end
        expQ.push_back(e);
      end else if (i == n - 1) begin
        expQ.push_back(e);
        for (int p = k + 1; p < 4; p++) begin
          z.word = (p == 3) ? 32'(len) : 32'h0;
          z.dec  = 4'h0;
          z.idx  = 2'(p);
          z.bl   = (p == 3);
          z.bp   = (p == 3);
          expQ.push_back(z);
        end
      end else begin
        expQ.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input int bytes, input logic last, input logic dec);
    int waitCycles = 0;
    pdi       = data;
    pdi_bytes = 3'(bytes);
    pdi_last  = last;
    dec_mode  = dec;
    pdi_valid = 1'b1;
    @(negedge clk);
    while (!pdi_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!pdi_ready) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL accept_timeout: got pdi_ready=%0b expected 1", pdi_ready);
    end
    @(posedge clk);
    #1;
    pdi_valid = 1'b0;
    pdi_last  = 1'b0;
  endtask

  task automatic sendSegment(input int n);
    modelSegment(n);
    for (int i = 0; i < n; i++) applyStimulus(segData[i], segBytes[i], (i == n - 1), segDec[i]);
  endtask

  task automatic waitDrain();
    int c = 0;
    while (expQ.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    checkOutput("drain_remaining", 32'(expQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clearObs();
    obsWord.delete();
    obsDec.delete();
    obsIdx.delete();
    obsBl.delete();
    obsBp.delete();
  endtask

  // Every consumed word is checked against the next predicted word.
  always @(negedge clk) begin
    if (rst && o_valid && o_ready) begin
      if (expQ.size() == 0) begin
        checkCount++;
        errCount++;
        $display("[TB] FAIL extra_word: got %h expected no word", pdi_o);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("pdi_o", pdi_o, monExp.word);
        checkOutput("decrypt_o", 32'(decrypt_o), 32'(monExp.dec));
        checkOutput("word_idx", 32'(word_idx), 32'(monExp.idx));
        checkOutput("blk_last", 32'(blk_last), 32'(monExp.bl));
        checkOutput("blk_partial", 32'(blk_partial), 32'(monExp.bp));
      end
      obsWord.push_back(pdi_o);
      obsDec.push_back(decrypt_o);
      obsIdx.push_back(word_idx);
      obsBl.push_back(blk_last);
      obsBp.push_back(blk_partial);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] heldWord;
    rst       = 1'b0;
    pdi       = 32'h0;
    pdi_valid = 1'b0;
    pdi_bytes = 3'd0;
    pdi_last  = 1'b0;
    dec_mode  = 1'b0;
    o_ready   = 1'b1;
    #12;
    checkOutput("rst_o_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_pdi_o", pdi_o, 32'h0);
    checkOutput("rst_decrypt_o", 32'(decrypt_o), 32'd0);
    checkOutput("rst_word_idx", 32'(word_idx), 32'd0);
    checkOutput("rst_blk_last", 32'(blk_last), 32'd0);
    checkOutput("rst_blk_partial", 32'(blk_partial), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Four full words ending exactly on a block boundary.
    clearObs();
    segData[0] = 32'h11111111; segData[1] = 32'h22222222;
    segData[2] = 32'h33333333; segData[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) begin segBytes[i] = 4; segDec[i] = 1'b0; end
    sendSegment(4);
    waitDrain();
    checkOutput("t1_word0", obsWord[0], 32'h11111111);
    checkOutput("t1_word3", obsWord[3], 32'h44444444);
    checkOutput("t1_bl2", 32'(obsBl[2]), 32'd0);
    checkOutput("t1_bl3", 32'(obsBl[3]), 32'd1);
    checkOutput("t1_bp3", 32'(obsBp[3]), 32'd0);

    // Single two-byte word, decrypt mode.
    clearObs();
    segData[0] = 32'hAABBCCDD; segBytes[0] = 2; segDec[0] = 1'b1;
    sendSegment(1);
    waitDrain();
    checkOutput("t2_word0", obsWord[0], 32'hAABB0000);
    checkOutput("t2_dec0", 32'(obsDec[0]), 32'hC);
    checkOutput("t2_word1", obsWord[1], 32'h0);
    checkOutput("t2_word3", obsWord[3], 32'h00000002);
    checkOutput("t2_dec3", 32'(obsDec[3]), 32'h0);
    checkOutput("t2_bp3", 32'(obsBp[3]), 32'd1);

    // Empty segment.
    clearObs();
    segData[0] = 32'hFFFFFFFF; segBytes[0] = 0; segDec[0] = 1'b1;
    sendSegment(1);
    waitDrain();
    checkOutput("t3_count", 32'(obsWord.size()), 32'd4);
    checkOutput("t3_word0", obsWord[0], 32'h0);
    checkOutput("t3_word3", obsWord[3], 32'h0);
    checkOutput("t3_bl3", 32'(obsBl[3]), 32'd1);
    checkOutput("t3_bp3", 32'(obsBp[3]), 32'd1);

    // Fifteen bytes: length lands in byte 15 of the last data word.
    clearObs();
    segData[0] = 32'h11111111; segData[1] = 32'h22222222;
    segData[2] = 32'h33333333; segData[3] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin segBytes[i] = 4; segDec[i] = 1'b1; end
    segBytes[3] = 3;
    sendSegment(4);
    waitDrain();
    checkOutput("t4_word3", obsWord[3], 32'hDEADBE0F);
    checkOutput("t4_dec3", 32'(obsDec[3]), 32'hE);
    checkOutput("t4_dec0", 32'(obsDec[0]), 32'hF);
    checkOutput("t4_bp3", 32'(obsBp[3]), 32'd1);

    // Two-block segment: second block holds five bytes.
    clearObs();
    for (int i = 0; i < 6; i++) begin
      segData[i]  = 32'h01020304 + 32'(i) * 32'h10101010;
      segBytes[i] = 4;
      segDec[i]   = 1'b0;
    end
    segBytes[5] = 1;
    sendSegment(6);
    waitDrain();
    checkOutput("t5_count", 32'(obsWord.size()), 32'd8);
    checkOutput("t5_bl3", 32'(obsBl[3]), 32'd0);
    checkOutput("t5_word5", obsWord[5], 32'h51000000);
    checkOutput("t5_word7", obsWord[7], 32'h00000005);

    // Back-pressure in the middle of padding.
    clearObs();
    segData[0] = 32'h0A0B0C0D; segBytes[0] = 4; segDec[0] = 1'b0;
    sendSegment(1);
    @(posedge clk);
    #1;
    o_ready  = 1'b0;
    heldWord = pdi_o;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_o_valid", 32'(o_valid), 32'd1);
      checkOutput("stall_pdi_o", pdi_o, heldWord);
      checkOutput("stall_word_idx", 32'(word_idx), 32'd1);
      checkOutput("stall_pdi_ready", 32'(pdi_ready), 32'd0);
    end
    o_ready = 1'b1;
    waitDrain();
    checkOutput("stall_count", 32'(obsWord.size()), 32'd4);
    checkOutput("stall_word3", obsWord[3], 32'h00000004);

    // Reset while the block is being padded.
    clearObs();
    o_ready = 1'b0;
    segData[0] = 32'hCAFEF00D; segBytes[0] = 1; segDec[0] = 1'b1;
    sendSegment(1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_o_valid", 32'(o_valid), 32'd0);
    checkOutput("mid_rst_pdi_o", pdi_o, 32'h0);
    checkOutput("mid_rst_decrypt_o", 32'(decrypt_o), 32'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    o_ready = 1'b1;
    clearObs();
    segData[0] = 32'h12345678; segBytes[0] = 4; segDec[0] = 1'b0;
    sendSegment(1);
    waitDrain();
    checkOutput("post_rst_count", 32'(obsWord.size()), 32'd4);
    checkOutput("post_rst_idx0", 32'(obsIdx[0]), 32'd0);
    checkOutput("post_rst_word0", obsWord[0], 32'h12345678);
    checkOutput("post_rst_word3", obsWord[3], 32'h00000004);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
